// File: rtl/accelerator_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : accelerator_mul_share_arb
// Purpose : Shares one signed DIN0_WIDTH x DIN1_WIDTH multiplier among
//           NUM_REQ requesters. A round-robin arbiter picks the requester.
//           A two-stage pipeline follows: S1 holds the operands and the id,
//           and S2 holds the product and the id. Results come back in the
//           order the requests were accepted.
// Ports   : ap_clk    - clock, rising edge
//           ap_rst_n  - asynchronous active-low reset
//           req_valid - per-requester operand valid       [NUM_REQ]
//           req_ready - per-requester grant (one-hot/zero) [NUM_REQ]
//           req_din0  - packed signed operand 0            [NUM_REQ*DIN0_WIDTH]
//           req_din1  - packed signed operand 1            [NUM_REQ*DIN1_WIDTH]
//           res_valid - result valid
//           res_ready - downstream accept
//           res_dout  - product, wrapped to DOUT_WIDTH bits
//           res_id    - index of the requester owning res_dout
//           busy      - any pipeline stage occupied
// Revision: 1.0 - initial release
// ============================================================================
module accelerator_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 40
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [DOUT_WIDTH-1:0]            res_dout,
  output logic [$clog2(NUM_REQ)-1:0]       res_id,
  output logic                             busy
);

  localparam int              IDW       = $clog2(NUM_REQ);
  localparam int              PW        = DIN0_WIDTH + DIN1_WIDTH;
  localparam logic [IDW:0]    C_NUM_REQ = NUM_REQ[IDW:0];

  // Pipeline state
  logic                          s1_v_q,    s1_v_d;
  logic signed [DIN0_WIDTH-1:0]  s1_din0_q, s1_din0_d;
  logic signed [DIN1_WIDTH-1:0]  s1_din1_q, s1_din1_d;
  logic [IDW-1:0]                s1_id_q,   s1_id_d;
  logic                          s2_v_q,    s2_v_d;
  logic [DOUT_WIDTH-1:0]         s2_dout_q, s2_dout_d;
  logic [IDW-1:0]                s2_id_q,   s2_id_d;
  logic [IDW-1:0]                ptr_q,     ptr_d;

  // Combinational helpers
  logic                          s2_free;
  logic                          s1_accept;
  logic                          grant_found;
  logic [IDW-1:0]                grant_idx;
  logic [IDW:0]                  cand;
  logic [IDW:0]                  ptr_nxt;
  logic                          fire;
  logic [DIN0_WIDTH-1:0]         sel_din0;
  logic [DIN1_WIDTH-1:0]         sel_din1;
  logic signed [PW-1:0]          prod_full;
  logic [DOUT_WIDTH-1:0]         prod_fit;

  // S2 may load when it is empty or being drained this cycle. S1 may accept
  // when it is empty or it can move into S2 on this edge.
  assign s2_free   = !s2_v_q || res_ready;
  assign s1_accept = !s1_v_q || s2_free;

  // Round-robin search starting at ptr_q. The sum ptr_q+k is below
  // 2*NUM_REQ, so one conditional subtract is enough to wrap it.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= C_NUM_REQ) begin
        cand = cand - C_NUM_REQ;
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Grant is gated by reset so req_ready drops as soon as reset asserts,
  // not only after the next clock.
  always_comb begin
    req_ready = '0;
    if (ap_rst_n && s1_accept && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign fire = |req_ready;

  // Operand mux for the granted requester.
  always_comb begin
    sel_din0 = '0;
    sel_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_din0 = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        sel_din1 = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
  end

  // The shared multiplier. Both operands are sign-extended to the full
  // product width, so the product is exact.
  assign prod_full = PW'(s1_din0_q) * PW'(s1_din1_q);

  generate
    if (DOUT_WIDTH <= PW) begin : g_trunc
      assign prod_fit = prod_full[DOUT_WIDTH-1:0];
    end else begin : g_sext
      assign prod_fit = {{(DOUT_WIDTH-PW){prod_full[PW-1]}}, prod_full};
    end
  endgenerate

  // Next-state logic
  always_comb begin
    ptr_nxt   = {1'b0, grant_idx} + {{IDW{1'b0}}, 1'b1};
    if (ptr_nxt >= C_NUM_REQ) begin
      ptr_nxt = '0;
    end
    ptr_d     = fire ? ptr_nxt[IDW-1:0] : ptr_q;

    s1_v_d    = s1_accept ? fire : s1_v_q;
    s1_din0_d = fire ? sel_din0  : s1_din0_q;
    s1_din1_d = fire ? sel_din1  : s1_din1_q;
    s1_id_d   = fire ? grant_idx : s1_id_q;

    s2_v_d    = s2_v_q;
    s2_dout_d = s2_dout_q;
    s2_id_d   = s2_id_q;
    if (s2_free) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_dout_d = prod_fit;
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_v_q    <= 1'b0;
      s1_din0_q <= '0;
      s1_din1_q <= '0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_dout_q <= '0;
      s2_id_q   <= '0;
      ptr_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_din0_q <= s1_din0_d;
      s1_din1_q <= s1_din1_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_dout_q <= s2_dout_d;
      s2_id_q   <= s2_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign res_valid = s2_v_q;
  assign res_dout  = s2_dout_q;
  assign res_id    = s2_id_q;
  assign busy      = s1_v_q || s2_v_q;

endmodule
`default_nettype wire
